// File: rtl/intc_8051_if.sv
// Interrupt controller <-> peripheral/SFR/CPU signal bundle.
// master = peripheral/CPU side, slave = intc_8051.
interface intc_8051_if;
  logic       i_int0_n;
  logic       i_int1_n;
  logic       i_tf0;
  logic       i_tf1;
  logic       i_ri_ti;
  logic [7:0] i_ie;
  logic [4:0] i_ip;
  logic [1:0] i_it;
  logic [1:0] i_flag_clr;
  logic       i_ack;
  logic       i_reti;
  logic       o_irq;
  logic [7:0] o_vector;
  logic [1:0] o_ie_flags;
  logic [1:0] o_tf_clr;

  modport master (
    output i_int0_n, i_int1_n, i_tf0, i_tf1, i_ri_ti,
    output i_ie, i_ip, i_it, i_flag_clr, i_ack, i_reti,
    input  o_irq, o_vector, o_ie_flags, o_tf_clr
  );

  modport slave (
    input  i_int0_n, i_int1_n, i_tf0, i_tf1, i_ri_ti,
    input  i_ie, i_ip, i_it, i_flag_clr, i_ack, i_reti,
    output o_irq, o_vector, o_ie_flags, o_tf_clr
  );
endinterface

// File: rtl/intc_8051.sv
// 8051 interrupt controller: external edge/level detect, two-level priority arbitration, in-service nesting.
// Optional INTC_PIN_SYNC_EN: 2-flop synchronizer on INT0/INT1 pins (adds 2 clocks of latency).
module intc_8051 #(
  parameter logic [7:0]  VECTOR_BASE   = 8'h03,
  parameter int unsigned VECTOR_STRIDE = 8
) (
  input logic       i_clk,
  input logic       i_rst,
  intc_8051_if.slave bus
);

  typedef enum logic [2:0] {
    SRC_INT0 = 3'd0,
    SRC_TF0  = 3'd1,
    SRC_INT1 = 3'd2,
    SRC_TF1  = 3'd3,
    SRC_SER  = 3'd4
  } src_e;

  logic [1:0] pin;

`ifdef INTC_PIN_SYNC_EN
  logic [1:0] sync1, sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {bus.i_int1_n, bus.i_int0_n};
      sync2 <= sync1;
    end
  end

  assign pin = sync2;
`else
  assign pin = {bus.i_int1_n, bus.i_int0_n};
`endif

  logic [1:0] pin_q;
  logic [1:0] ext_flag;
  logic [1:0] ext_fall;
  logic [1:0] ext_ack_clr;
  logic       isr_hi, isr_lo;
  logic       isr_hi_n, isr_lo_n;
  src_e       cur_src;
  logic       irq_q;
  logic [7:0] vec_q;
  logic [1:0] tf_clr_q;
  logic       ack_go;
  logic [4:0] req, pend, elig_hi, elig_lo, pick;
  logic       win_valid;
  src_e       win_src;
  logic       unused_ie;

  assign unused_ie = ^bus.i_ie[6:5];

  function automatic logic [7:0] vec_of(input src_e s);
    return VECTOR_BASE + 8'(VECTOR_STRIDE * 32'(s));
  endfunction

  assign ack_go   = bus.i_ack & irq_q;
  assign ext_fall = pin_q & ~pin;

  always_comb begin
    ext_ack_clr = '0;
    if (ack_go) begin
      ext_ack_clr[0] = (cur_src == SRC_INT0);
      ext_ack_clr[1] = (cur_src == SRC_INT1);
    end
  end

  // Edge mode: a new falling edge beats a same-cycle software/ack clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pin_q    <= '1;
      ext_flag <= '0;
    end else begin
      pin_q <= pin;
      for (int unsigned i = 0; i < 2; i++) begin
        if (bus.i_it[i])
          ext_flag[i] <= ext_fall[i] | (ext_flag[i] & ~(bus.i_flag_clr[i] | ext_ack_clr[i]));
        else
          ext_flag[i] <= ~pin[i];
      end
    end
  end

  assign req     = {bus.i_ri_ti, bus.i_tf1, ext_flag[1], bus.i_tf0, ext_flag[0]};
  assign pend    = req & bus.i_ie[4:0] & {5{bus.i_ie[7]}};
  assign elig_hi = pend & bus.i_ip & {5{~isr_hi}};
  assign elig_lo = pend & ~bus.i_ip & {5{~(isr_hi | isr_lo)}};
  assign pick    = (elig_hi != '0) ? elig_hi : elig_lo;

  always_comb begin
    win_valid = 1'b0;
    win_src   = SRC_INT0;
    for (int unsigned i = 5; i > 0; i--) begin
      if (pick[i-1]) begin
        win_valid = 1'b1;
        win_src   = src_e'(3'(i - 1));
      end
    end
  end

  // RETI retires the innermost level before a same-cycle ack enters a new one.
  always_comb begin
    isr_hi_n = isr_hi;
    isr_lo_n = isr_lo;
    if (bus.i_reti) begin
      if (isr_hi) isr_hi_n = 1'b0;
      else        isr_lo_n = 1'b0;
    end
    if (ack_go) begin
      if (bus.i_ip[cur_src]) isr_hi_n = 1'b1;
      else                   isr_lo_n = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      isr_hi   <= 1'b0;
      isr_lo   <= 1'b0;
      irq_q    <= 1'b0;
      vec_q    <= '0;
      cur_src  <= SRC_INT0;
      tf_clr_q <= '0;
    end else begin
      isr_hi   <= isr_hi_n;
      isr_lo   <= isr_lo_n;
      irq_q    <= win_valid & ~ack_go;
      vec_q    <= (win_valid & ~ack_go) ? vec_of(win_src) : '0;
      cur_src  <= win_src;
      tf_clr_q <= {ack_go & (cur_src == SRC_TF1), ack_go & (cur_src == SRC_TF0)};
    end
  end

  assign bus.o_irq      = irq_q;
  assign bus.o_vector   = vec_q;
  assign bus.o_ie_flags = ext_flag;
  assign bus.o_tf_clr   = tf_clr_q;

endmodule

// File: doc/intc_8051.md
Name: intc_8051

Overview:
- Interrupt controller for the 8051 core. Detects external interrupt events on INT0/INT1 (edge or level) and collects the timer and serial requests.
- Arbitrates the pending requests using the 8051 two-level priority and fixed polling order, then presents one vector to the CPU sequencer.
- Tracks in-service levels so that nesting follows 8051 rules.
- Sits between the peripheral/SFR block and the CPU control FSM.

Parameters:
- VECTOR_BASE, 8'h03, vector address of source 0.
- VECTOR_STRIDE, 8, address distance between consecutive source vectors.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_int0_n  in  1  external interrupt 0 pin, active-low
- i_int1_n  in  1  external interrupt 1 pin, active-low
- i_tf0  in  1  timer0 overflow flag, level, owned by the timer block
- i_tf1  in  1  timer1 overflow flag, level
- i_ri_ti  in  1  serial RI|TI, level
- i_ie  in  8  IE SFR (bit7 EA, bit4 ES, bit3 ET1, bit2 EX1, bit1 ET0, bit0 EX0)
- i_ip  in  5  IP SFR bits 4:0 (1 = high priority)
- i_it  in  2  {IT1,IT0}: 1 = falling-edge mode, 0 = level mode
- i_flag_clr  in  2  {IE1,IE0} software clear pulse (TCON write)
- i_ack  in  1  CPU accepts the current vector (1-cycle pulse)
- i_reti  in  1  CPU executed RETI (1-cycle pulse)
- o_irq  out  1  request to the CPU
- o_vector  out  8  vector address valid while o_irq=1
- o_ie_flags  out  2  {IE1,IE0} for TCON readback
- o_tf_clr  out  2  {TF1,TF0} hardware clear pulse to the timer

Behaviour:
- Reset: o_irq=0, o_vector=0, o_ie_flags=0, o_tf_clr=0, in-service bits isr_lo=isr_hi=0. Edge-detect delay regs reset to 1 (pin idle high). Reset mid-service abandons all state.
- Source index / vector: 0 INT0, 1 TF0, 2 INT1, 3 TF1, 4 serial. Vector = VECTOR_BASE + idx*VECTOR_STRIDE (03,0B,13,1B,23).
- External flag in edge mode:
  - Sets when the registered sample is 1 and the current pin is 0 (one-shot of the negated pin).
  - Clears on i_ack for that source or on i_flag_clr.
  - A set and a clear in the same cycle: set wins.
- External flag in level mode: flag <= ~pin each cycle. Not cleared by ack.
- pend[i] = flag[i] & IE enable bit[i] & EA.
- Eligibility:
  - High-priority source: eligible iff isr_hi=0.
  - Low-priority source: eligible iff isr_hi=0 and isr_lo=0.
- Winner: any eligible high-priority source beats any low-priority one. Within a level, the lowest index wins.
- Outputs are registered: o_irq and o_vector update every clock from the current winner. Latency from a pin edge sample to o_irq is 2 clocks (flag reg, then output reg).
- i_ack while o_irq=1:
  - Sets isr_hi or isr_lo per IP of the current o_vector's source.
  - Edge-mode external: clears the flag. Timer: pulses o_tf_clr for 1 cycle. Serial: no clear.
  - Forces o_irq=0 in the next cycle. Re-arbitration follows from updated state.
- i_ack while o_irq=0: ignored.
- i_reti: clears isr_hi if set, else clears isr_lo. With none in service it is ignored.
- i_ack and i_reti in the same cycle: reti applies first, then ack.
- A level source deasserting before ack withdraws o_irq on the next clock. The vector may change without an ack.

Optional Feature:
- INTC_PIN_SYNC_EN defined: a 2-flop synchronizer (reset to 1) is placed on each external pin before edge/level logic. External latency becomes 4 clocks.
- Undefined: pins are used directly and are assumed synchronous to i_clk.

Test Plan:
- Edge mode: i_it=2'b01, i_ie=8'h81, pull INT0 low at cycle 10 and hold it low → o_irq=1, o_vector=8'h03 at cycle 12. Ack at cycle 14 → IE0=0, o_irq=0, no retrigger while held low.
- Level mode: i_it=0, INT1 low, i_ie=8'h84 → o_vector=8'h13. Ack+reti with the pin still low → re-request after reti.
- Priority: TF0 and serial both pending, i_ie=8'h92, i_ip=5'b10000 → vector 8'h23 first. After reti, vector 8'h0B, with o_tf_clr[0] pulsing on its ack.
- Nesting: low-priority TF1 in service (isr_lo=1), then high-priority INT0 edge arrives → preempts (vector 03). A low-priority TF0 arriving during that time stays masked until both retis.
- Same-cycle set/clear: INT0 falling edge in the same cycle as i_flag_clr[0] → IE0=1. Reset asserted while o_irq=1 → o_irq=0 and the isr bits cleared on the next clock.
- EA=0 with all flags set → o_irq stays 0. o_ie_flags still shows the edge flags.
